// File: rtl/row_uram_arbiter_pkg.sv
// Shared types and default widths for the row-level URAM arbiter and its picker.
package row_uram_arbiter_pkg;

    localparam int URAM_ADDR_WIDTH = 12;
    localparam int URAM_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LOCKED,
        RELEASE,
        FULL
    } row_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: one-hot first set bit of mask strictly after
// pointer, wrapping around; valid is low when mask is empty.
module rr_priority_picker #(
    parameter int N = 8
) (
    input  logic [N-1:0]         mask,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         pick,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    always_comb begin
        logic [PW-1:0] idx;
        pick  = '0;
        valid = 1'b0;
        idx   = pointer;
        // Walk N positions starting just after the pointer; wrap explicitly so N need not be a power of two.
        for (int off = 0; off < N; off++) begin
            idx = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
            if (!valid && mask[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/row_uram_arbiter.sv
// Row controller sharing one URAM port among NUM_CORES cores with round-robin, lock hold
// and a per-epoch barrier. Define ROW_URAM_ARB_WATCHDOG_EN to add the stuck-lock watchdog.
module row_uram_arbiter
    import row_uram_arbiter_pkg::*;
#(
    parameter int NUM_CORES   = 8,
    parameter int ADDR_WIDTH  = URAM_ADDR_WIDTH,
    parameter int DATA_WIDTH  = URAM_DATA_WIDTH,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CORES-1:0]            i_core_req,
    input  logic [NUM_CORES-1:0]            i_core_locked,
    output logic [NUM_CORES-1:0]            o_core_grant,
    input  logic [NUM_CORES-1:0]            i_core_uram_en,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] i_core_uram_addr,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] i_core_uram_wr_data,
    input  logic [NUM_CORES-1:0]            i_core_uram_wr_en,
    output logic                            o_uram_en,
    output logic [ADDR_WIDTH-1:0]           o_uram_addr,
    output logic [DATA_WIDTH-1:0]           o_uram_wr_data,
    output logic                            o_uram_wr_en,
    input  logic                            i_drain_done,
    output logic                            o_uram_emptied,
    output logic                            o_wdog_err
);

    localparam int PW = $clog2(NUM_CORES);

    row_arb_state_t         state_reg, state_next;
    logic [NUM_CORES-1:0]   served_reg;
    logic [PW-1:0]          ptr_reg;
    logic [NUM_CORES-1:0]   g_onehot_reg;
    logic [PW-1:0]          g_idx_reg;
    logic                   emptied_reg;
    logic [NUM_CORES-1:0]   eligible;
    logic [NUM_CORES-1:0]   pick;
    logic                   pick_valid;
    logic [PW-1:0]          pick_idx;
    logic                   wdog_hit;
    logic                   g_locked;
    logic                   g_req;
    logic [ADDR_WIDTH-1:0]  core_addr [NUM_CORES];
    logic [DATA_WIDTH-1:0]  core_data [NUM_CORES];

    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core_bus
        assign core_addr[gi] = i_core_uram_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign core_data[gi] = i_core_uram_wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Cores already served this epoch stay masked until the consumer drains the URAM.
    assign eligible = i_core_req & ~served_reg;

    rr_priority_picker #(.N(NUM_CORES)) u_picker (
        .mask    (eligible),
        .pointer (ptr_reg),
        .pick    (pick),
        .valid   (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (pick[k]) pick_idx = PW'(k);
        end
    end

    assign g_locked = i_core_locked[g_idx_reg];
    assign g_req    = i_core_req[g_idx_reg];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (emptied_reg && pick_valid) state_next = GRANT;
            GRANT: begin
                if (wdog_hit)      state_next = RELEASE;
                else if (g_locked) state_next = LOCKED;
                else if (!g_req)   state_next = IDLE;
            end
            LOCKED:  if (!g_locked || wdog_hit) state_next = RELEASE;
            RELEASE: state_next = (&served_reg) ? FULL : IDLE;
            FULL:    if (i_drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_reg   <= '0;
            ptr_reg      <= PW'(NUM_CORES - 1);
            g_onehot_reg <= '0;
            g_idx_reg    <= '0;
            emptied_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (state_next == GRANT) begin
                        g_onehot_reg <= pick;
                        g_idx_reg    <= pick_idx;
                    end
                end
                GRANT, LOCKED: begin
                    // An abandoned grant (GRANT -> IDLE) leaves served and the pointer untouched.
                    if (state_next == RELEASE) begin
                        served_reg[g_idx_reg] <= 1'b1;
                        ptr_reg               <= g_idx_reg;
                    end
                end
                RELEASE: if (state_next == FULL) emptied_reg <= 1'b0;
                FULL: begin
                    if (state_next == IDLE) begin
                        served_reg  <= '0;
                        emptied_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_core_grant   = '0;
        o_uram_en      = 1'b0;
        o_uram_addr    = '0;
        o_uram_wr_data = '0;
        o_uram_wr_en   = 1'b0;
        if (state_reg == GRANT || state_reg == LOCKED) begin
            o_core_grant   = g_onehot_reg;
            o_uram_en      = i_core_uram_en[g_idx_reg];
            o_uram_addr    = core_addr[g_idx_reg];
            o_uram_wr_data = core_data[g_idx_reg];
            o_uram_wr_en   = i_core_uram_wr_en[g_idx_reg];
        end
    end

    assign o_uram_emptied = emptied_reg;

`ifdef ROW_URAM_ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    logic [WW-1:0] wdog_cnt_reg;
    logic          wdog_err_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt_reg <= '0;
            wdog_err_reg <= 1'b0;
        end else begin
            if (state_reg == IDLE && state_next == GRANT)
                wdog_cnt_reg <= '0;
            else if (state_reg == GRANT || state_reg == LOCKED)
                wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
            if (wdog_hit) wdog_err_reg <= 1'b1;
        end
    end

    // Fires on the WDOG_CYCLES-th cycle of a session, forcing it to end like a normal release.
    assign wdog_hit   = (state_reg == GRANT || state_reg == LOCKED) &&
                        (wdog_cnt_reg == WW'(WDOG_CYCLES - 1));
    assign o_wdog_err = wdog_err_reg;
`else
    assign wdog_hit   = 1'b0;
    assign o_wdog_err = 1'b0;
`endif

endmodule

// File: tb/tb_row_uram_arbiter.sv
// Directed table-driven bench for row_uram_arbiter (4 cores), plus async-reset and watchdog sequences.
module tb_row_uram_arbiter;

    localparam int NC = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     i_core_req;
    logic [NC-1:0]     i_core_locked;
    logic [NC-1:0]     o_core_grant;
    logic [NC-1:0]     i_core_uram_en;
    logic [NC*AW-1:0]  i_core_uram_addr;
    logic [NC*DW-1:0]  i_core_uram_wr_data;
    logic [NC-1:0]     i_core_uram_wr_en;
    logic              o_uram_en;
    logic [AW-1:0]     o_uram_addr;
    logic [DW-1:0]     o_uram_wr_data;
    logic              o_uram_wr_en;
    logic              i_drain_done;
    logic              o_uram_emptied;
    logic              o_wdog_err;

    row_uram_arbiter #(
        .NUM_CORES   (NC),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .WDOG_CYCLES (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .i_core_req          (i_core_req),
        .i_core_locked       (i_core_locked),
        .o_core_grant        (o_core_grant),
        .i_core_uram_en      (i_core_uram_en),
        .i_core_uram_addr    (i_core_uram_addr),
        .i_core_uram_wr_data (i_core_uram_wr_data),
        .i_core_uram_wr_en   (i_core_uram_wr_en),
        .o_uram_en           (o_uram_en),
        .o_uram_addr         (o_uram_addr),
        .o_uram_wr_data      (o_uram_wr_data),
        .o_uram_wr_en        (o_uram_wr_en),
        .i_drain_done        (i_drain_done),
        .o_uram_emptied      (o_uram_emptied),
        .o_wdog_err          (o_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] req;
        logic [NC-1:0] lock;
        logic          drain;
        logic [NC-1:0] en;
        logic [NC-1:0] wr;
        logic [NC-1:0] g;
        logic          empt;
        logic          uen;
        logic          uwr;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic [NC-1:0] req, input logic [NC-1:0] lock, input logic drain,
                       input logic [NC-1:0] en, input logic [NC-1:0] wr, input logic [NC-1:0] g,
                       input logic empt, input logic uen, input logic uwr);
        vec_t v;
        v.req = req; v.lock = lock; v.drain = drain; v.en = en; v.wr = wr;
        v.g = g; v.empt = empt; v.uen = uen; v.uwr = uwr;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] core_addr(input int k);
        return AW'(12'h100 + k);
    endfunction

    function automatic logic [DW-1:0] core_data(input int k);
        return 32'hA500_0000 + DW'(k * 32'h11);
    endfunction

    // Checks the URAM mux against the expected granted core (none when g is zero).
    task automatic check_bus(input string tag, input logic [NC-1:0] g,
                             input logic uen, input logic uwr);
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ea = '0;
        ed = '0;
        for (int k = 0; k < NC; k++) begin
            if (g[k]) begin
                ea = core_addr(k);
                ed = core_data(k);
            end
        end
        check({tag, " grant"}, 64'(o_core_grant), 64'(g));
        check({tag, " onehot0"}, 64'($onehot0(o_core_grant)), 64'd1);
        check({tag, " uram_en"}, 64'(o_uram_en), 64'(uen));
        check({tag, " uram_wr_en"}, 64'(o_uram_wr_en), 64'(uwr));
        check({tag, " uram_addr"}, 64'(o_uram_addr), 64'(ea));
        check({tag, " uram_wr_data"}, 64'(o_uram_wr_data), 64'(ed));
    endtask

    initial begin
        int held;
        int waited;

        for (int k = 0; k < NC; k++) begin
            i_core_uram_addr[k*AW +: AW]    = core_addr(k);
            i_core_uram_wr_data[k*DW +: DW] = core_data(k);
        end
        reset = 1'b0;
        i_core_req = '0; i_core_locked = '0; i_core_uram_en = '0; i_core_uram_wr_en = '0;
        i_drain_done = 1'b0;

        //  req   lock  drn en    wr    grant empt uen uwr
        add(4'h0, 4'h0, 0, 4'h0, 4'h0, 4'h0, 1, 0, 0);  // idle after reset
        add(4'h2, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // core1 req sampled
        add(4'h2, 4'h2, 0, 4'hF, 4'hF, 4'h2, 1, 1, 1);  // granted, locks
        add(4'h2, 4'h2, 1, 4'hF, 4'hF, 4'h2, 1, 1, 1);  // stray drain ignored
        add(4'h2, 4'h2, 0, 4'hF, 4'h0, 4'h2, 1, 1, 0);
        add(4'h0, 4'h0, 0, 4'hF, 4'h0, 4'h2, 1, 1, 0);  // unlock, grant still up
        add(4'h0, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // gap cycle
        add(4'h2, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // served core1 masked
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // cores 0,2,3, ptr=1
        add(4'hD, 4'h4, 0, 4'hF, 4'hF, 4'h4, 1, 1, 1);  // core2 first
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h4, 1, 1, 1);
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // core2 still requesting, skipped
        add(4'hD, 4'h8, 0, 4'hF, 4'hF, 4'h8, 1, 1, 1);  // core3
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h8, 1, 1, 1);
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);
        add(4'hD, 4'h1, 0, 4'hF, 4'hF, 4'h1, 1, 1, 1);  // core0 last
        add(4'hD, 4'h0, 0, 4'hF, 4'hF, 4'h1, 1, 1, 1);
        add(4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // final RELEASE
        add(4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0);  // FULL, emptied low
        add(4'hF, 4'h0, 0, 4'hF, 4'hF, 4'h0, 0, 0, 0);
        add(4'h1, 4'h0, 1, 4'hF, 4'hF, 4'h0, 0, 0, 0);  // drain pulse
        add(4'h1, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // epoch reopened
        add(4'h1, 4'h0, 0, 4'hF, 4'hF, 4'h1, 1, 1, 1);  // core0 granted again
        add(4'h0, 4'h0, 0, 4'hF, 4'hF, 4'h1, 1, 1, 1);  // core0 abandons
        add(4'h8, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);
        add(4'h8, 4'h0, 0, 4'hF, 4'hF, 4'h8, 1, 1, 1);  // core3 granted
        add(4'h0, 4'h0, 0, 4'hF, 4'hF, 4'h8, 1, 1, 1);  // core3 abandons
        add(4'h0, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);
        add(4'h8, 4'h0, 0, 4'hF, 4'hF, 4'h0, 1, 0, 0);  // core3 not marked served
        add(4'h8, 4'h8, 0, 4'hF, 4'hF, 4'h8, 1, 1, 1);
        add(4'h8, 4'h8, 0, 4'hF, 4'hF, 4'h8, 1, 1, 1);  // locked, writing

        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_bus("reset", 4'h0, 1'b0, 1'b0);
        check("reset emptied", 64'(o_uram_emptied), 64'd1);
        check("reset wdog_err", 64'(o_wdog_err), 64'd0);
        reset = 1'b1;

        foreach (vq[i]) begin
            i_core_req        = vq[i].req;
            i_core_locked     = vq[i].lock;
            i_drain_done      = vq[i].drain;
            i_core_uram_en    = vq[i].en;
            i_core_uram_wr_en = vq[i].wr;
            #1;
            $display("vec %0d req=%b lock=%b drain=%b grant=%b emptied=%b en=%b wr=%b addr=%h",
                     i, vq[i].req, vq[i].lock, vq[i].drain, o_core_grant, o_uram_emptied,
                     o_uram_en, o_uram_wr_en, o_uram_addr);
            check_bus($sformatf("vec%0d", i), vq[i].g, vq[i].uen, vq[i].uwr);
            check($sformatf("vec%0d emptied", i), 64'(o_uram_emptied), 64'(vq[i].empt));
            @(negedge clk);
        end

        // Reset mid-LOCKED with a write in flight: outputs must clear without a clock edge.
        #2 reset = 1'b0;
        #1;
        $display("async reset mid-lock: grant=%b en=%b wr=%b emptied=%b",
                 o_core_grant, o_uram_en, o_uram_wr_en, o_uram_emptied);
        check_bus("async_rst", 4'h0, 1'b0, 1'b0);
        check("async_rst emptied", 64'(o_uram_emptied), 64'd1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Core0 holds its lock forever while core1 waits.
        i_core_req = 4'h3; i_core_locked = 4'h1; i_core_uram_en = 4'hF; i_core_uram_wr_en = 4'hF;
        i_drain_done = 1'b0;
        held = 0;
        @(negedge clk); #1;
        while (o_core_grant == 4'h1 && held < 40) begin
            held++;
            @(negedge clk); #1;
        end
        $display("stuck lock: core0 grant held %0d cycles, wdog_err=%b", held, o_wdog_err);
`ifdef ROW_URAM_ARB_WATCHDOG_EN
        check("wdog hold cycles", 64'(held), 64'd16);
        check("wdog err set", 64'(o_wdog_err), 64'd1);
        waited = 0;
        while (o_core_grant != 4'h2 && waited < 8) begin
            waited++;
            @(negedge clk); #1;
        end
        $display("after watchdog: grant=%b after %0d cycles", o_core_grant, waited);
        check("wdog next grant core1", 64'(o_core_grant), 64'h2);
        check("wdog next grant gap", 64'(waited), 64'd2);
        i_core_req = '0; i_core_locked = '0;
        repeat (4) @(negedge clk);
        #1;
        check("wdog err sticky", 64'(o_wdog_err), 64'd1);
        check("wdog idle grant", 64'(o_core_grant), 64'h0);
`else
        waited = 0;
        check("no wdog hold cycles", 64'(held), 64'd40);
        check("no wdog err", 64'(o_wdog_err), 64'd0);
        check("no wdog uram_addr", 64'(o_uram_addr), 64'(core_addr(0)));
        i_core_req = '0; i_core_locked = '0;
        repeat (3) @(negedge clk);
        #1;
        check("no wdog release grant", 64'(o_core_grant), 64'h0);
        check("no wdog err after", 64'(o_wdog_err), 64'(waited));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
